// File: rtl/gmii_frame_tx.sv
// Ethernet transmit framer: AXI-Stream payload bytes in, GMII out with preamble/SFD,
// zero padding to a minimum length, CRC32 FCS and a fixed inter-frame gap.
module gmii_frame_tx #(
  parameter int MIN_FRAME_LEN = 60,
  parameter int IFG_CYCLES    = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        gmii_tx_er,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SFD, S_PAYLOAD, S_PAD, S_FCS, S_IFG, S_DROP
  } state_t;

  localparam logic [15:0] MIN_LEN = 16'(MIN_FRAME_LEN);
  localparam logic [15:0] IFG_LEN = 16'(IFG_CYCLES);

  state_t      state_q, state_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        tx_er_q, tx_er_d;
  logic        tready_q, tready_d;
  logic        busy_q, busy_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        underrun_q, underrun_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] step_q, step_d;
  logic [31:0] crc_q, crc_d;
  logic        bad_q, bad_d;

  logic [15:0] byte_inc;
  logic [31:0] fcs_word;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign byte_inc = (byte_cnt_q == 16'hFFFF) ? 16'hFFFF : byte_cnt_q + 16'd1;
  assign fcs_word = ~crc_q;

  always_comb begin
    state_d       = state_q;
    txd_d         = 8'h00;
    tx_en_d       = 1'b0;
    tx_er_d       = 1'b0;
    underrun_d    = 1'b0;
    frame_count_d = frame_count_q;
    byte_cnt_d    = byte_cnt_q;
    step_d        = step_q;
    crc_d         = crc_q;
    bad_d         = bad_q;

    case (state_q)
      S_IDLE, S_IFG: begin
        // step_q counts low cycles in IFG; IDLE may start at any time
        if (state_q == S_IFG && step_q < IFG_LEN) begin
          step_d = step_q + 16'd1;
        end else if (s_axis_tvalid) begin
          state_d    = S_PREAMBLE;
          step_d     = 16'd1;
          txd_d      = 8'h55;
          tx_en_d    = 1'b1;
          byte_cnt_d = 16'd0;
          crc_d      = 32'hFFFF_FFFF;
          bad_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_PREAMBLE: begin
        tx_en_d = 1'b1;
        if (step_q == 16'd7) begin
          txd_d   = 8'hD5;
          state_d = S_SFD;
        end else begin
          txd_d  = 8'h55;
          step_d = step_q + 16'd1;
        end
      end

      S_SFD, S_PAYLOAD: begin
        tx_en_d = 1'b1;
        if (s_axis_tvalid) begin
          txd_d      = s_axis_tdata;
          crc_d      = crc_byte(crc_q, s_axis_tdata);
          byte_cnt_d = byte_inc;
          if (s_axis_tlast) begin
            bad_d   = s_axis_tuser;
            step_d  = 16'd0;
            state_d = (byte_inc < MIN_LEN) ? S_PAD : S_FCS;
          end else begin
            state_d = S_PAYLOAD;
          end
        end else begin
          // starved mid-frame: poison the frame on the wire and discard the rest
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
          state_d    = S_DROP;
        end
      end

      S_PAD: begin
        tx_en_d    = 1'b1;
        crc_d      = crc_byte(crc_q, 8'h00);
        byte_cnt_d = byte_inc;
        if (byte_inc >= MIN_LEN) begin
          step_d  = 16'd0;
          state_d = S_FCS;
        end
      end

      S_FCS: begin
        if (step_q < 16'd4) begin
          tx_en_d = 1'b1;
          tx_er_d = bad_q;
          txd_d   = fcs_word[{step_q[1:0], 3'b000} +: 8];
          step_d  = step_q + 16'd1;
        end else begin
          frame_count_d = frame_count_q + 16'd1;
          step_d        = 16'd1;
          state_d       = S_IFG;
        end
      end

      S_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          frame_count_d = frame_count_q + 16'd1;
          step_d        = 16'd1;
          state_d       = S_IFG;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign tready_d = (state_d == S_SFD) || (state_d == S_PAYLOAD) || (state_d == S_DROP);
  assign busy_d   = (state_d != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      txd_q         <= 8'h00;
      tx_en_q       <= 1'b0;
      tx_er_q       <= 1'b0;
      tready_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= 16'd0;
      underrun_q    <= 1'b0;
      byte_cnt_q    <= 16'd0;
      step_q        <= 16'd0;
      crc_q         <= 32'hFFFF_FFFF;
      bad_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      txd_q         <= txd_d;
      tx_en_q       <= tx_en_d;
      tx_er_q       <= tx_er_d;
      tready_q      <= tready_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      underrun_q    <= underrun_d;
      byte_cnt_q    <= byte_cnt_d;
      step_q        <= step_d;
      crc_q         <= crc_d;
      bad_q         <= bad_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign gmii_txd      = txd_q;
  assign gmii_tx_en    = tx_en_q;
  assign gmii_tx_er    = tx_er_q;
  assign busy          = busy_q;
  assign frame_count   = frame_count_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Directed bench for gmii_frame_tx: one default instance and one with padding disabled,
// wire capture on the falling edge, per-frame decode against hand values and a CRC32 model.
module tb_gmii_frame_tx;
  logic clk = 1'b0;
  logic rst;
  always #4 clk = ~clk;

  logic [7:0] tdata;
  logic       tvalid, tlast, tuser, sel;

  logic       tready_a, tx_en_a, tx_er_a, busy_a, underrun_a;
  logic [7:0] txd_a;
  logic [15:0] fc_a;
  logic       tready_b, tx_en_b, tx_er_b, busy_b, underrun_b;
  logic [7:0] txd_b;
  logic [15:0] fc_b;

  gmii_frame_tx u_dut_a (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & ~sel), .s_axis_tready(tready_a),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .gmii_txd(txd_a), .gmii_tx_en(tx_en_a), .gmii_tx_er(tx_er_a),
    .busy(busy_a), .frame_count(fc_a), .underrun(underrun_a)
  );

  gmii_frame_tx #(.MIN_FRAME_LEN(0), .IFG_CYCLES(12)) u_dut_b (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid & sel), .s_axis_tready(tready_b),
    .s_axis_tlast(tlast), .s_axis_tuser(tuser),
    .gmii_txd(txd_b), .gmii_tx_en(tx_en_b), .gmii_tx_er(tx_er_b),
    .busy(busy_b), .frame_count(fc_b), .underrun(underrun_b)
  );

  logic       tready, tx_en, tx_er, busy, underrun;
  logic [7:0] txd;
  logic [15:0] fc;
  assign tready   = sel ? tready_b   : tready_a;
  assign tx_en    = sel ? tx_en_b    : tx_en_a;
  assign tx_er    = sel ? tx_er_b    : tx_er_a;
  assign busy     = sel ? busy_b     : busy_a;
  assign underrun = sel ? underrun_b : underrun_a;
  assign txd      = sel ? txd_b      : txd_a;
  assign fc       = sel ? fc_b       : fc_a;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // wire capture; a new test_id clears everything
  logic [7:0] cap_d[$];
  bit         cap_e[$];
  int runs[$], gaps[$];
  int cur_run = 0, cur_gap = 0, urun = 0, seen_id = 0, test_id = 0;
  bit seen = 0;

  always @(negedge clk) begin
    if (seen_id != test_id) begin
      cap_d.delete(); cap_e.delete(); runs.delete(); gaps.delete();
      cur_run = 0; cur_gap = 0; urun = 0; seen = 0; seen_id = test_id;
    end
    if (tx_en) begin
      cap_d.push_back(txd); cap_e.push_back(tx_er);
      if (cur_run == 0 && seen) gaps.push_back(cur_gap);
      cur_run++; cur_gap = 0;
    end else begin
      if (cur_run != 0) begin runs.push_back(cur_run); seen = 1; end
      cur_run = 0; cur_gap++;
    end
    if (underrun) urun++;
  end

  function automatic logic [7:0] pb(input int seed, input int i);
    return 8'((seed * 37 + i * 11 + 3) & 255);
  endfunction

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int k = 0; k < 8; k++)
      r = (r[0] ^ d[k]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] exp_fcs(input int seed, input int len, input int minlen);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < len; i++) c = crc_upd(c, pb(seed, i));
    for (int i = len; i < minlen; i++) c = crc_upd(c, 8'h00);
    return ~c;
  endfunction

  task automatic push(input logic [7:0] d, input bit last, input bit user);
    int n = 0;
    tdata = d; tlast = last; tuser = user; tvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!tready && n < 200);
    if (!tready) chk("handshake_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  task automatic send(input int seed, input int len, input bit user);
    for (int i = 0; i < len; i++) push(pb(seed, i), i == len - 1, user && (i == len - 1));
  endtask

  task automatic idle_in();
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || tx_en) && n < 3000);
    chk(tag, (busy || tx_en), 0);
    @(posedge clk); #1;
  endtask

  // decode one captured frame starting at off
  task automatic chk_frame(input string tag, input int off, input int seed, input int len,
                           input int minlen, input bit bad);
    int tot, nb, ne, nf;
    logic [31:0] f;
    tot = (len < minlen) ? minlen : len;
    chk({tag, "_caplen_ok"}, (cap_d.size() >= off + tot + 12), 1);
    if (cap_d.size() < off + tot + 12) return;
    nb = 0;
    for (int i = 0; i < 7; i++) if (cap_d[off + i] != 8'h55) nb++;
    chk({tag, "_preamble_bad"}, nb, 0);
    chk({tag, "_sfd"}, cap_d[off + 7], 8'hD5);
    nb = 0;
    for (int i = 0; i < len; i++) if (cap_d[off + 8 + i] != pb(seed, i)) nb++;
    chk({tag, "_payload_bad"}, nb, 0);
    if (tot > len) begin
      nb = 0;
      for (int i = len; i < tot; i++) if (cap_d[off + 8 + i] != 8'h00) nb++;
      chk({tag, "_pad_bad"}, nb, 0);
    end
    f = {cap_d[off + tot + 11], cap_d[off + tot + 10], cap_d[off + tot + 9], cap_d[off + tot + 8]};
    chk({tag, "_fcs"}, f, exp_fcs(seed, len, minlen));
    ne = 0; nf = 0;
    for (int i = 0; i < tot + 12; i++) if (cap_e[off + i]) ne++;
    for (int i = tot + 8; i < tot + 12; i++) if (cap_e[off + i]) nf++;
    chk({tag, "_er_total"}, ne, bad ? 4 : 0);
    chk({tag, "_er_fcs"}, nf, bad ? 4 : 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tvalid = 1'b0; tdata = 8'h00; tlast = 1'b0; tuser = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_txd", txd_a, 0);
    chk("rst_tx_en", tx_en_a, 0);
    chk("rst_tx_er", tx_er_a, 0);
    chk("rst_tready", tready_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_fcount", fc_a, 0);
    chk("rst_underrun", underrun_a, 0);
    chk("rst_b_tx_en", tx_en_b, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // "123456789" with padding disabled
    sel = 1'b1; test_id++;
    for (int i = 0; i < 9; i++) push(8'(8'h31 + i), i == 8, 1'b0);
    idle_in(); wait_idle("t1_idle");
    chk("t1_len", cap_d.size(), 21);
    if (cap_d.size() >= 21) begin
      chk("t1_pre0", cap_d[0], 8'h55);
      chk("t1_pre6", cap_d[6], 8'h55);
      chk("t1_sfd", cap_d[7], 8'hD5);
      chk("t1_d0", cap_d[8], 8'h31);
      chk("t1_d8", cap_d[16], 8'h39);
      chk("t1_fcs0", cap_d[17], 8'h26);
      chk("t1_fcs1", cap_d[18], 8'h39);
      chk("t1_fcs2", cap_d[19], 8'hF4);
      chk("t1_fcs3", cap_d[20], 8'hCB);
    end
    chk("t1_runs", runs.size(), 1);
    if (runs.size() >= 1) chk("t1_run_len", runs[0], 21);
    chk("t1_fcount", fc_b, 1);

    // 14-byte frame padded to 60
    sel = 1'b0; test_id++;
    send(1, 14, 1'b0);
    idle_in(); wait_idle("t2_idle");
    chk("t2_len", cap_d.size(), 72);
    if (runs.size() >= 1) chk("t2_run_len", runs[0], 72);
    chk_frame("t2", 0, 1, 14, 60, 1'b0);
    chk("t2_fcount", fc_a, 1);

    // back-to-back, tvalid held high across the boundary
    test_id++;
    send(2, 20, 1'b0);
    send(3, 61, 1'b0);
    idle_in(); wait_idle("t3_idle");
    chk("t3_runs", runs.size(), 2);
    if (runs.size() >= 2) begin
      chk("t3_run0", runs[0], 72);
      chk("t3_run1", runs[1], 73);
    end
    chk("t3_gaps", gaps.size(), 1);
    if (gaps.size() >= 1) chk("t3_gap", gaps[0], 12);
    chk_frame("t3a", 0, 2, 20, 60, 1'b0);
    chk_frame("t3b", 72, 3, 61, 60, 1'b0);
    chk("t3_fcount", fc_a, 3);

    // underrun after 5 of 20 bytes
    test_id++;
    for (int i = 0; i < 5; i++) push(pb(4, i), 1'b0, 1'b0);
    tvalid = 1'b0;
    @(posedge clk); #1;
    for (int i = 5; i < 20; i++) push(pb(4, i), i == 19, 1'b0);
    idle_in(); wait_idle("t4_idle");
    chk("t4_len", cap_d.size(), 14);
    if (runs.size() >= 1) chk("t4_run_len", runs[0], 14);
    if (cap_d.size() >= 14) begin
      chk("t4_byte4", cap_d[12], pb(4, 4));
      chk("t4_err_txd", cap_d[13], 8'h00);
      chk("t4_err_er", cap_e[13], 1);
      chk("t4_er_before", cap_e[12], 0);
    end
    chk("t4_underrun_pulses", urun, 1);
    chk("t4_fcount", fc_a, 4);
    test_id++;
    send(5, 14, 1'b0);
    idle_in(); wait_idle("t4n_idle");
    if (runs.size() >= 1) chk("t4n_run_len", runs[0], 72);
    chk_frame("t4n", 0, 5, 14, 60, 1'b0);
    chk("t4n_fcount", fc_a, 5);

    // bad frame flagged with tuser on tlast
    test_id++;
    send(6, 64, 1'b1);
    idle_in(); wait_idle("t5_idle");
    if (runs.size() >= 1) chk("t5_run_len", runs[0], 76);
    chk_frame("t5", 0, 6, 64, 60, 1'b1);
    chk("t5_fcount", fc_a, 6);

    // asynchronous reset in the middle of the payload
    test_id++;
    for (int i = 0; i < 8; i++) push(pb(7, i), 1'b0, 1'b0);
    chk("t6_pre_en", tx_en_a, 1);
    #1 rst = 1'b1;
    #1;
    chk("t6_txd", txd_a, 0);
    chk("t6_tx_en", tx_en_a, 0);
    chk("t6_tx_er", tx_er_a, 0);
    chk("t6_tready", tready_a, 0);
    chk("t6_busy", busy_a, 0);
    chk("t6_fcount", fc_a, 0);
    idle_in();
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    test_id++;
    send(8, 14, 1'b0);
    idle_in(); wait_idle("t6n_idle");
    chk("t6n_len", cap_d.size(), 72);
    chk_frame("t6n", 0, 8, 14, 60, 1'b0);
    chk("t6n_fcount", fc_a, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
